// File: rtl/mem_seq_reducer.sv
// Memory scan sequencer: sums LEN words from BASE, optionally writes the low byte to DST.
// Define MEM_REDUCER_MAX_EN to add the max_val output (largest word read).
module mem_seq_reducer #(
    parameter int ADR_W  = 5,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADR_W-1:0]  base_adr,
    input  logic [ADR_W-1:0]  len,
    input  logic [ADR_W-1:0]  dst_adr,
    input  logic              wb,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_REDUCER_MAX_EN
    ,
    output logic [DATA_W-1:0] max_val
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADR_W-1:0]   idx_q, idx_d;
    logic [ADR_W-1:0]   base_q, base_d;
    logic [ADR_W-1:0]   len_q, len_d;
    logic [ADR_W-1:0]   dst_q, dst_d;
    logic               wb_q, wb_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               last_rd;

    assign last_rd = (idx_q == (len_q - ADR_W'(1)));

`ifdef MEM_REDUCER_MAX_EN
    logic [DATA_W-1:0]  max_q, max_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            dst_q   <= '0;
            wb_q    <= 1'b0;
            sum_q   <= '0;
`ifdef MEM_REDUCER_MAX_EN
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            len_q   <= len_d;
            dst_q   <= dst_d;
            wb_q    <= wb_d;
            sum_q   <= sum_d;
`ifdef MEM_REDUCER_MAX_EN
            max_q   <= max_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        len_d   = len_q;
        dst_d   = dst_q;
        wb_d    = wb_q;
        sum_d   = sum_q;
`ifdef MEM_REDUCER_MAX_EN
        max_d   = max_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_adr;
                    len_d  = len;
                    dst_d  = dst_adr;
                    wb_d   = wb;
                    sum_d  = '0;
                    idx_d  = '0;
`ifdef MEM_REDUCER_MAX_EN
                    max_d  = '0;
`endif
                    if (len != '0) begin
                        state_d = S_READ;
                    end else if (wb) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                sum_d = sum_q + SUM_W'(mem_rdata);
                idx_d = idx_q + ADR_W'(1);
`ifdef MEM_REDUCER_MAX_EN
                if (mem_rdata > max_q) begin
                    max_d = mem_rdata;
                end
`endif
                if (last_rd) begin
                    state_d = wb_q ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory pins decode from state and latched operands only, never from mem_rdata.
    always_comb begin
        mem_adr   = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_READ: begin
                mem_adr = base_q + idx_q;
                busy    = 1'b1;
            end
            S_WRITE: begin
                mem_adr   = dst_q;
                mem_wdata = sum_q[DATA_W-1:0];
                mem_wen   = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                mem_adr = '0;
            end
        endcase
    end

    assign sum = sum_q;

`ifdef MEM_REDUCER_MAX_EN
    assign max_val = max_q;
`endif

endmodule

// File: tb/tb_mem_seq_reducer.sv
// Directed bench for mem_seq_reducer with a 32x8 comb-read memory model.
module tb_mem_seq_reducer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  base_adr;
    logic [4:0]  len;
    logic [4:0]  dst_adr;
    logic        wb;
    logic        busy;
    logic        done;
    logic [12:0] sum;
    logic [4:0]  mem_adr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic [7:0]  mem_rdata;
`ifdef MEM_REDUCER_MAX_EN
    logic [7:0]  max_val;
`endif

    logic [7:0]  mem [32];
    logic [7:0]  ld_img [32];
    logic [7:0]  img [32];
    logic [7:0]  exp_mem [32];
    logic        ld;

    int n_cmp;
    int n_bad;

    mem_seq_reducer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_adr  (base_adr),
        .len       (len),
        .dst_adr   (dst_adr),
        .wb        (wb),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata)
`ifdef MEM_REDUCER_MAX_EN
        ,
        .max_val   (max_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_adr];

    always @(posedge clk) begin
        if (ld) begin
            mem <= ld_img;
        end else if (mem_wen) begin
            mem[mem_adr] <= mem_wdata;
        end
    end

    typedef struct {
        int         kind;
        logic [4:0] base;
        logic [4:0] len;
        logic [4:0] dst;
        logic       wb;
        int         exp_sum;
        int         exp_lat;
        int         exp_busy;
        int         exp_wen;
        int         exp_max;
        int         disturb;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // kind 0: m[10..19]=1..10; kind 1: adds wrap words; kind 2: kind 0 with m[20]=0xAA
    task automatic make_img(input int kind);
        for (int i = 0; i < 32; i++) img[i] = 8'd0;
        for (int i = 0; i < 10; i++) img[10+i] = 8'(i + 1);
        if (kind == 1) begin
            img[30] = 8'd200;
            img[31] = 8'd100;
            img[0]  = 8'd7;
            img[1]  = 8'd3;
        end
        if (kind == 2) img[20] = 8'hAA;
    endtask

    task automatic load_mem();
        @(negedge clk);
        ld_img = img;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run(input vec_t v, input int id);
        int cyc;
        int nb;
        int nw;
        int nr;
        int bad_adr;
        int bad_idle;
        int diffs;
        make_img(v.kind);
        load_mem();
        exp_mem = img;
        if (v.wb) exp_mem[v.dst] = 8'(v.exp_sum);
        @(negedge clk);
        base_adr = v.base;
        len      = v.len;
        dst_adr  = v.dst;
        wb       = v.wb;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nb = 0; nw = 0; nr = 0; bad_adr = 0; bad_idle = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy) nb++;
            if (mem_wen) nw++;
            if (busy && !mem_wen) begin
                if (mem_adr !== 5'(v.base + 5'(nr))) bad_adr++;
                nr++;
            end
            if (!mem_wen && mem_wdata !== 8'd0) bad_idle++;
            if (cyc == v.disturb) begin
                start    = 1'b1;
                base_adr = 5'd0;
                len      = 5'd5;
                dst_adr  = 5'd7;
                wb       = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        $display("vector %0d base=%0d len=%0d wb=%0d", id, v.base, v.len, v.wb);
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", cyc, v.exp_lat);
        chk("busy_cycles", nb, v.exp_busy);
        chk("wen_cycles", nw, v.exp_wen);
        chk("read_count", nr, 32'(v.len));
        chk("adr_sequence", bad_adr, 0);
        chk("wdata_idle", bad_idle, 0);
        chk("adr_in_done", 32'(mem_adr), 0);
        chk("busy_in_done", 32'(busy), 0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("sum", 32'(sum), v.exp_sum);
`ifdef MEM_REDUCER_MAX_EN
        chk("max_val", 32'(max_val), v.exp_max);
`endif
        diffs = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) diffs++;
        chk("mem_contents", diffs, 0);
    endtask

    initial begin
        int nw;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        base_adr = '0;
        len = '0;
        dst_adr = '0;
        wb = 1'b0;
        ld = 1'b0;
        for (int i = 0; i < 32; i++) ld_img[i] = 8'd0;

        //         kind base len dst wb sum lat busy wen max dist
        tv[0] = '{0, 5'd10, 5'd10, 5'd20, 1'b1, 55, 12, 11, 1, 10, 0};
        tv[1] = '{1, 5'd30, 5'd4,  5'd5,  1'b1, 310, 6, 5, 1, 200, 0};
        tv[2] = '{0, 5'd0,  5'd0,  5'd2,  1'b1, 0, 2, 1, 1, 0, 0};
        tv[3] = '{0, 5'd10, 5'd0,  5'd15, 1'b1, 0, 2, 1, 1, 0, 0};
        tv[4] = '{0, 5'd10, 5'd0,  5'd20, 1'b0, 0, 1, 0, 0, 0, 0};
        tv[5] = '{0, 5'd10, 5'd3,  5'd20, 1'b0, 6, 4, 3, 0, 3, 0};
        tv[6] = '{0, 5'd10, 5'd10, 5'd20, 1'b1, 55, 12, 11, 1, 10, 3};
        tv[7] = '{1, 5'd31, 5'd3,  5'd0,  1'b1, 110, 5, 4, 1, 100, 0};
        tv[8] = '{0, 5'd0,  5'd31, 5'd9,  1'b0, 55, 32, 31, 0, 10, 0};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_mem_adr", 32'(mem_adr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_mem_wen", 32'(mem_wen), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run(tv[k], k);

        // Reset during READ: immediate idle, no write, then a clean rerun.
        make_img(2);
        load_mem();
        @(negedge clk);
        base_adr = 5'd10;
        len      = 5'd10;
        dst_adr  = 5'd20;
        wb       = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_wen", 32'(mem_wen), 0);
        chk("mid_rst_adr", 32'(mem_adr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nw = 0;
        for (int i = 0; i < 15; i++) begin
            if (mem_wen || busy) nw++;
            @(negedge clk);
        end
        chk("post_rst_activity", nw, 0);
        chk("post_rst_m20", 32'(mem[20]), 32'hAA);
        run(tv[0], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
